cc_miss_req_ctrl: RTL and testbench

Sequences cache-line refills for the cache controller.
- Accepts miss requests from the tag-compare stage.
- Issues one AXI AR burst per miss: 8 beats x 64 bit, one 512-bit line.
- Pushes the miss address into the miss-address FIFO, which the data fill unit pops when the first R beat arrives.
- Tracks outstanding refills and throttles new misses until fill-unit line writes retire them.

---
 rtl/cc_miss_req_ctrl.sv | 111 +++++++++++
 tb/tb_cc_miss_req_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cc_miss_req_ctrl.sv
// Miss request controller: one AXI AR burst per cache-line miss, mirrored into the miss-address FIFO.
// Optional macro CC_CRITICAL_WORD_FIRST_EN selects a WRAP burst that starts at the missing beat.
module cc_miss_req_ctrl #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_BEATS     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  input  logic        fill_done_i,
  output logic [2:0]  outstanding_o,
  output logic        err_o
);

  // Only the address bits that reach the bus are kept.
`ifdef CC_CRITICAL_WORD_FIRST_EN
  localparam int ADDR_LO = 3;
  localparam logic [1:0] BURST_TYPE = 2'b10;
`else
  localparam int ADDR_LO = 6;
  localparam logic [1:0] BURST_TYPE = 2'b01;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:ADDR_LO] addr_q;
  logic [2:0]        outstanding_q;
  logic              err_q;
  logic              accept;
  logic              ar_hs;
  logic [31:0]       line_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_arready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_req_ready_o = (state_q == IDLE) &&
                       (outstanding_q < 3'(MAX_OUTSTANDING)) &&
                       !miss_addr_fifo_full_i;
    mem_arvalid_o    = (state_q == REQ);
  end

  assign accept    = miss_req_valid_i & miss_req_ready_o;
  assign ar_hs     = mem_arvalid_o & mem_arready_i;
  assign line_addr = {addr_q, {ADDR_LO{1'b0}}};

  assign mem_araddr_o           = line_addr;
  assign mem_arlen_o            = 4'(BURST_BEATS - 1);
  assign mem_arsize_o           = 3'b011;
  assign mem_arburst_o          = BURST_TYPE;
  assign miss_addr_fifo_wren_o  = ar_hs;
  assign miss_addr_fifo_wdata_o = line_addr;
  assign outstanding_o          = outstanding_q;
  assign err_o                  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else if (accept) begin
      addr_q <= miss_req_addr_i[31:ADDR_LO];
    end
  end

  // A fill with nothing in flight is a protocol violation; the count holds at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      case ({ar_hs, fill_done_i})
        2'b10:   outstanding_q <= outstanding_q + 3'd1;
        2'b01:   if (outstanding_q != 3'd0) outstanding_q <= outstanding_q - 3'd1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (fill_done_i && (outstanding_q == 3'd0)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Table-driven bench for cc_miss_req_ctrl; expected line addresses follow CC_CRITICAL_WORD_FIRST_EN.
module tb_cc_miss_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req_valid_i = 1'b0;
  logic [31:0] miss_req_addr_i = '0;
  logic        miss_req_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i = 1'b0;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        miss_addr_fifo_full_i = 1'b0;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic        fill_done_i = 1'b0;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cc_miss_req_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_valid_i       (miss_req_valid_i),
    .miss_req_addr_i        (miss_req_addr_i),
    .miss_req_ready_o       (miss_req_ready_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .fill_done_i            (fill_done_i),
    .outstanding_o          (outstanding_o),
    .err_o                  (err_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        arready;
    logic        full;
    logic        fill;
    logic        exp_ready;
    logic        exp_arvalid;
    logic        exp_wren;
    logic [31:0] exp_addr;
    logic        chk_addr;
    logic [2:0]  exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

`ifdef CC_CRITICAL_WORD_FIRST_EN
  localparam logic [1:0] EXP_BURST = 2'b10;
  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:3], 3'b000};
  endfunction
`else
  localparam logic [1:0] EXP_BURST = 2'b01;
  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:6], 6'b000000};
  endfunction
`endif

  function automatic vec_t mk(input logic valid, input logic [31:0] addr,
                              input logic arready, input logic full, input logic fill,
                              input logic e_ready, input logic e_arvalid, input logic e_wren,
                              input logic chk, input logic [31:0] e_addr,
                              input logic [2:0] e_out, input logic e_err);
    vec_t v;
    v.valid = valid; v.addr = addr; v.arready = arready; v.full = full; v.fill = fill;
    v.exp_ready = e_ready; v.exp_arvalid = e_arvalid; v.exp_wren = e_wren;
    v.chk_addr = chk; v.exp_addr = e_addr; v.exp_out = e_out; v.exp_err = e_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    miss_req_valid_i      = v.valid;
    miss_req_addr_i       = v.addr;
    mem_arready_i         = v.arready;
    miss_addr_fifo_full_i = v.full;
    fill_done_i           = v.fill;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    checkOutput({tag, ".ready"},   32'(miss_req_ready_o),      32'(v.exp_ready));
    checkOutput({tag, ".arvalid"}, 32'(mem_arvalid_o),         32'(v.exp_arvalid));
    checkOutput({tag, ".wren"},    32'(miss_addr_fifo_wren_o), 32'(v.exp_wren));
    checkOutput({tag, ".out"},     32'(outstanding_o),         32'(v.exp_out));
    checkOutput({tag, ".err"},     32'(err_o),                 32'(v.exp_err));
    if (v.chk_addr) begin
      checkOutput({tag, ".araddr"}, mem_araddr_o,           v.exp_addr);
      checkOutput({tag, ".wdata"},  miss_addr_fifo_wdata_o, v.exp_addr);
    end
  endtask

  initial begin
    // reset, first miss with arready already high
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(1, 32'h0000_1248, 1, 0, 0, 1, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 1, 1, 1, line_of(32'h0000_1248), 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 1, 0));
    // arready held low for five cycles
    vecs.push_back(mk(1, 32'h0000_2010, 0, 0, 0, 1, 0, 0, 0, 32'h0, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 32'hdead_beef, 0, 0, 0, 0, 1, 0, 1, line_of(32'h0000_2010), 1, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 1, 1, 1, line_of(32'h0000_2010), 1, 0));
    // handshake coincident with fill_done at outstanding 2
    vecs.push_back(mk(1, 32'h0000_303c, 0, 0, 0, 1, 0, 0, 0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 1, 0, 1, 1, 1, line_of(32'h0000_303c), 2, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 2, 0));
    // fill up to four outstanding
    vecs.push_back(mk(1, 32'h0000_4000, 1, 0, 0, 1, 0, 0, 0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 1, 1, 1, line_of(32'h0000_4000), 2, 0));
    vecs.push_back(mk(1, 32'h0000_5078, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3, 0));
    vecs.push_back(mk(1, 32'h0000_6000, 1, 0, 0, 0, 1, 1, 1, line_of(32'h0000_5078), 3, 0));
    vecs.push_back(mk(1, 32'h0000_6000, 1, 0, 0, 0, 0, 0, 0, 32'h0, 4, 0));
    vecs.push_back(mk(1, 32'h0000_6000, 1, 0, 0, 0, 0, 0, 0, 32'h0, 4, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 4, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3, 0));
    // FIFO full blocks accept; arvalid holds once issued
    vecs.push_back(mk(1, 32'h0000_7000, 0, 1, 0, 0, 0, 0, 0, 32'h0, 3, 0));
    vecs.push_back(mk(1, 32'h0000_7000, 0, 1, 0, 0, 0, 0, 0, 32'h0, 3, 0));
    vecs.push_back(mk(1, 32'h0000_7010, 0, 0, 0, 1, 0, 0, 0, 32'h0, 3, 0));
    vecs.push_back(mk(0, 32'h0, 0, 1, 0, 0, 1, 0, 1, line_of(32'h0000_7010), 3, 0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0, 1, 1, 1, line_of(32'h0000_7010), 3, 0));
    // drain, then a spurious fill at zero
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 4, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 3, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 2, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 1, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0, 1));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    checkOutput("arlen",   32'(mem_arlen_o),   32'd7);
    checkOutput("arsize",  32'(mem_arsize_o),  32'd3);
    checkOutput("arburst", 32'(mem_arburst_o), 32'(EXP_BURST));

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(i, vecs[i]);
    end

    // reset while an AR is pending must abort it without a push
    @(negedge clk);
    applyStimulus(mk(1, 32'h0000_8000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    @(negedge clk);
    miss_req_valid_i = 1'b0;
    #1;
    checkOutput("rst.pre_arvalid", 32'(mem_arvalid_o), 32'd1);
    checkOutput("rst.pre_err",     32'(err_o),         32'd1);
    rst = 1'b1;
    mem_arready_i = 1'b1;
    #1;
    checkOutput("rst.arvalid", 32'(mem_arvalid_o),         32'd0);
    checkOutput("rst.wren",    32'(miss_addr_fifo_wren_o), 32'd0);
    checkOutput("rst.err",     32'(err_o),                 32'd0);
    checkOutput("rst.out",     32'(outstanding_o),         32'd0);
    checkOutput("rst.ready",   32'(miss_req_ready_o),      32'd1);
    checkOutput("rst.araddr",  mem_araddr_o,               32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst.wren",    32'(miss_addr_fifo_wren_o), 32'd0);
    checkOutput("post_rst.arvalid", 32'(mem_arvalid_o),         32'd0);
    checkOutput("post_rst.out",     32'(outstanding_o),         32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
